// File: rtl/stage_memory_pkg.sv
// Shared encodings for the memory-access pipeline stage.
package stage_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
    localparam logic [3:0] REG_NONE        = 4'h0;

endpackage

// File: rtl/stage_memory.sv
// Memory stage: ALU results pass through in one cycle; aligned loads/stores run as a single
// valid/ready bus transaction while the upstream pipeline is stalled.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_addr,
    input  logic [31:0]       in_val,
    input  logic              is_mem,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_val,
    input  logic              mem_write,
    output logic              stall,
    output logic [3:0]        fwd_addr,
    output logic [31:0]       fwd_val,
    output logic [3:0]        wb_addr,
    output logic [31:0]       wb_val,
    output logic              misalign,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    output logic              bus_req_write,
    input  logic              bus_resp_valid,
    input  logic [DATA_W-1:0] bus_resp_rdata
);

    state_e            r_state;
    state_e            w_state_d;
    logic              w_aligned;
    logic              w_stall;
    logic [3:0]        w_fwd_addr;
    logic [3:0]        r_wb_addr;
    logic [31:0]       r_wb_val;
    logic              r_misalign;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic              r_req_write;
    logic [3:0]        r_dest;

    assign w_aligned = (mem_addr[1:0] & WORD_ALIGN_MASK) == 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_stall    = 1'b0;
        w_fwd_addr = REG_NONE;
        case (r_state)
            IDLE: begin
                if (!is_mem) begin
                    w_fwd_addr = in_addr;
                end else if (w_aligned) begin
                    w_stall   = 1'b1;
                    w_state_d = REQ;
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (bus_req_ready) begin
                    w_state_d = WAIT;
                end
            end
            WAIT: begin
                w_stall = ~bus_resp_valid;
                if (bus_resp_valid) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Writeback defaults to a bubble; only a completed ALU op or a response overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_addr   <= REG_NONE;
            r_wb_val    <= '0;
            r_misalign  <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_write <= 1'b0;
            r_dest      <= REG_NONE;
        end else begin
            r_misalign <= 1'b0;
            r_wb_addr  <= REG_NONE;
            case (r_state)
                IDLE: begin
                    if (!is_mem) begin
                        r_wb_addr <= in_addr;
                        r_wb_val  <= in_val;
                    end else if (!w_aligned) begin
                        r_misalign <= 1'b1;
                    end else begin
                        r_req_valid <= 1'b1;
                        r_req_addr  <= mem_addr;
                        r_req_wdata <= mem_val;
                        r_req_write <= mem_write;
                        r_dest      <= mem_write ? REG_NONE : in_addr;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        r_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus_resp_valid) begin
                        r_wb_addr <= r_dest;
                        r_wb_val  <= r_req_write ? 32'h0 : 32'(bus_resp_rdata);
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall         = w_stall;
    assign fwd_addr      = w_fwd_addr;
    assign fwd_val       = in_val;
    assign wb_addr       = r_wb_addr;
    assign wb_val        = r_wb_val;
    assign misalign      = r_misalign;
    assign bus_req_valid = r_req_valid;
    assign bus_req_addr  = r_req_addr;
    assign bus_req_wdata = r_req_wdata;
    assign bus_req_write = r_req_write;

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed scenarios plus a random instruction stream against a
// transaction-level expectation of each instruction's outcome.
module tb_stage_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_addr;
    logic [31:0] in_val;
    logic        is_mem;
    logic [31:0] mem_addr;
    logic [31:0] mem_val;
    logic        mem_write;
    logic        stall;
    logic [3:0]  fwd_addr;
    logic [31:0] fwd_val;
    logic [3:0]  wb_addr;
    logic [31:0] wb_val;
    logic        misalign;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_req_write;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    stage_memory #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_addr       (in_addr),
        .in_val        (in_val),
        .is_mem        (is_mem),
        .mem_addr      (mem_addr),
        .mem_val       (mem_val),
        .mem_write     (mem_write),
        .stall         (stall),
        .fwd_addr      (fwd_addr),
        .fwd_val       (fwd_val),
        .wb_addr       (wb_addr),
        .wb_val        (wb_val),
        .misalign      (misalign),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_write (bus_req_write),
        .bus_resp_valid(bus_resp_valid),
        .bus_resp_rdata(bus_resp_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alu(input logic [3:0] a, input logic [31:0] v);
        is_mem         = 1'b0;
        in_addr        = a;
        in_val         = v;
        mem_addr       = $urandom;
        mem_write      = 1'($urandom);
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'($urandom);  // stray response in IDLE must be ignored
        #1;
        check("alu_stall", 32'(stall), 32'd0);
        check("alu_fwd_addr", 32'(fwd_addr), 32'(a));
        if (a != 4'd0) check("alu_fwd_val", fwd_val, v);
        tick();
        bus_resp_valid = 1'b0;
        check("alu_wb_addr", 32'(wb_addr), 32'(a));
        check("alu_wb_val", wb_val, v);
        check("alu_misalign", 32'(misalign), 32'd0);
        check("alu_req_valid", 32'(bus_req_valid), 32'd0);
    endtask

    task automatic do_misaligned(input logic [3:0] a, input logic [31:0] addr, input logic wr);
        is_mem         = 1'b1;
        in_addr        = a;
        in_val         = $urandom;
        mem_addr       = addr;
        mem_val        = $urandom;
        mem_write      = wr;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        #1;
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_fwd_addr", 32'(fwd_addr), 32'd0);
        tick();
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_wb_addr", 32'(wb_addr), 32'd0);
        check("mis_req_valid", 32'(bus_req_valid), 32'd0);
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic wr);
        check({tag, "_valid"}, 32'(bus_req_valid), 32'd1);
        check({tag, "_addr"}, bus_req_addr, addr);
        check({tag, "_wdata"}, bus_req_wdata, data);
        check({tag, "_write"}, 32'(bus_req_write), 32'(wr));
        check({tag, "_stall"}, 32'(stall), 32'd1);
        check({tag, "_fwd"}, 32'(fwd_addr), 32'd0);
    endtask

    // Complete memory access: ready after ready_dly REQ cycles, response after resp_dly
    // empty WAIT cycles. Expected writeback follows from the instruction alone.
    task automatic do_mem(input logic [3:0] dest, input logic [31:0] addr, input logic [31:0] data,
                          input logic wr, input int ready_dly, input int resp_dly,
                          input logic [31:0] rd);
        is_mem         = 1'b1;
        in_addr        = dest;
        in_val         = $urandom;
        mem_addr       = addr;
        mem_val        = data;
        mem_write      = wr;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        #1;
        check("mem_issue_stall", 32'(stall), 32'd1);
        check("mem_issue_fwd", 32'(fwd_addr), 32'd0);
        tick();
        check("mem_issue_wb", 32'(wb_addr), 32'd0);
        check("mem_issue_mis", 32'(misalign), 32'd0);
        for (int i = 0; i < ready_dly; i++) begin
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'($urandom);  // responses before acceptance are ignored
            #1;
            check_req("req_hold", addr, data, wr);
            tick();
            check("req_hold_wb", 32'(wb_addr), 32'd0);
        end
        bus_req_ready  = 1'b1;
        bus_resp_valid = 1'b0;
        #1;
        check_req("req_acc", addr, data, wr);
        tick();
        bus_req_ready = 1'b0;
        check("acc_valid", 32'(bus_req_valid), 32'd0);
        check("acc_wb", 32'(wb_addr), 32'd0);
        for (int i = 0; i < resp_dly; i++) begin
            bus_resp_rdata = $urandom;
            #1;
            check("wait_stall", 32'(stall), 32'd1);
            check("wait_fwd", 32'(fwd_addr), 32'd0);
            tick();
            check("wait_wb", 32'(wb_addr), 32'd0);
            check("wait_valid", 32'(bus_req_valid), 32'd0);
        end
        bus_resp_valid = 1'b1;
        bus_resp_rdata = rd;
        #1;
        check("resp_stall", 32'(stall), 32'd0);
        tick();
        bus_resp_valid = 1'b0;
        check("resp_wb_addr", 32'(wb_addr), wr ? 32'd0 : 32'(dest));
        check("resp_wb_val", wb_val, wr ? 32'd0 : rd);
        check("resp_valid", 32'(bus_req_valid), 32'd0);
        check("resp_mis", 32'(misalign), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] addr;
        int          kind;
        rst            = 1'b1;
        in_addr        = 4'd0;
        in_val         = 32'd0;
        is_mem         = 1'b0;
        mem_addr       = 32'd0;
        mem_val        = 32'd0;
        mem_write      = 1'b0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_rdata = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_val", wb_val, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_req_valid", 32'(bus_req_valid), 32'd0);
        check("rst_req_addr", bus_req_addr, 32'd0);
        check("rst_req_wdata", bus_req_wdata, 32'd0);
        check("rst_req_write", 32'(bus_req_write), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        do_alu(4'd3, 32'h0000_1234);
        do_mem(4'd5, 32'h100, 32'h0, 1'b0, 0, 1, 32'hDEAD_BEEF);
        do_mem(4'd6, 32'h200, 32'hCAFE_F00D, 1'b1, 3, 0, 32'h1357_9BDF);
        do_misaligned(4'd4, 32'h102, 1'b0);
        do_alu(4'd1, 32'h0BAD_F00D);
        check("mis_cleared", 32'(misalign), 32'd0);
        do_mem(4'd7, 32'h300, 32'h0, 1'b0, 0, 0, 32'h11);
        do_alu(4'd2, 32'h22);
        check("b2b_no_dup_req", 32'(bus_req_valid), 32'd0);

        // Reset while waiting for a response; the late response must be dropped.
        is_mem    = 1'b1;
        in_addr   = 4'd9;
        mem_addr  = 32'h400;
        mem_write = 1'b0;
        tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        rst           = 1'b1;
        is_mem        = 1'b0;
        in_addr       = 4'd0;
        in_val        = 32'd0;
        tick();
        rst = 1'b0;
        check("rstw_wb_addr", 32'(wb_addr), 32'd0);
        check("rstw_req_valid", 32'(bus_req_valid), 32'd0);
        check("rstw_stall", 32'(stall), 32'd0);
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h5555_AAAA;
        tick();
        bus_resp_valid = 1'b0;
        check("rstw_late_resp_wb", 32'(wb_addr), 32'd0);
        check("rstw_late_resp_val", wb_val, 32'd0);

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 3));
            addr = $urandom;
            if (kind == 0) begin
                do_alu(4'($urandom), $urandom);
            end else if (kind == 1) begin
                if (addr[1:0] == 2'b00) addr[0] = 1'b1;
                do_misaligned(4'($urandom), addr, 1'($urandom));
            end else begin
                addr[1:0] = 2'b00;
                do_mem(4'($urandom), addr, $urandom, 1'($urandom),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
Memory-access pipeline stage that sits directly after the execute stage and consumes its registered memory request (is_mem, mem_addr, mem_val, mem_write) plus its registered ALU result (out_addr, out_val). Non-memory instructions pass through to writeback in one cycle. Memory instructions are issued as single-word transactions on a valid/ready request channel with a separate response channel. The stage stalls the upstream pipeline until each transaction completes, then presents load data (or a bubble for stores) to writeback.

Parameters:
ADDR_W, 32, data-bus address width
DATA_W, 32, data word width; only word accesses are supported

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
in_addr  in  4  destination register from execute (0 = no writeback)
in_val  in  32  ALU result from execute
is_mem  in  1  current instruction is a load or store
mem_addr  in  ADDR_W  byte address of the access
mem_val  in  DATA_W  store data
mem_write  in  1  1 = store, 0 = load
stall  out  1  combinational; upstream holds all in_* and mem_* inputs while high
fwd_addr  out  4  combinational forward address to decode
fwd_val  out  32  combinational forward value
wb_addr  out  4  registered writeback destination
wb_val  out  32  registered writeback value
misalign  out  1  registered one-cycle fault pulse
bus_req_valid  out  1  request valid
bus_req_ready  in  1  request accepted
bus_req_addr  out  ADDR_W  registered request address
bus_req_wdata  out  DATA_W  registered store data
bus_req_write  out  1  registered request type
bus_resp_valid  in  1  response valid (required for both loads and stores)
bus_resp_rdata  in  DATA_W  load data

Behaviour:
- Reset: state IDLE; wb_addr=0, wb_val=0, misalign=0, bus_req_valid=0, bus_req_addr/wdata/write=0. A reset mid-transaction abandons the transaction; a late response arriving afterwards is ignored.
- FSM states:
  - IDLE
    - is_mem=0: stall=0; at the next edge wb_addr<=in_addr and wb_val<=in_val. Latency is 1 cycle.
    - is_mem=1 and mem_addr[1:0]!=0: no request is issued; stall=0; at the next edge misalign<=1, wb_addr<=0, and the state stays IDLE. The instruction is treated as a NOP.
    - is_mem=1 and aligned: stall=1; latch the address, data, write flag and destination (0 if store); at the next edge go to REQ with bus_req_valid<=1 and wb_addr<=0.
  - REQ
    - bus_req_valid=1; request fields are stable until accepted; stall=1.
    - On bus_req_ready: bus_req_valid<=0; go to WAIT.
  - WAIT
    - stall = ~bus_resp_valid.
    - On bus_resp_valid: wb_addr<=latched dest (0 for a store), wb_val<=bus_resp_rdata (0 for a store); go to IDLE. Upstream advances on this same edge.
- Responses never arrive in the same cycle as acceptance. bus_resp_valid in IDLE or REQ is ignored.
- Every stalled cycle writes a bubble: wb_addr<=0.
- misalign is high for exactly one cycle per fault, and is 0 otherwise.
- Forwarding in IDLE:
  - is_mem=0: fwd_addr=in_addr, fwd_val=in_val.
  - is_mem=1: fwd_addr=0, because load data is not yet available.
- Forwarding in REQ/WAIT: fwd_addr=0.
- Minimum latency of an aligned access, from the IDLE cycle to the wb update: 3 cycles (IDLE, REQ accepted immediately, WAIT with an immediate response).

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, REQ=2'd1, WAIT=2'd2
  - WORD_ALIGN_MASK=2'b11
  - REG_NONE=4'h0
- No sub-module: the FSM plus the request latch stays in one module.

Test Plan:
- ALU pass-through: in_addr=3, in_val=0x00001234, is_mem=0 -> next cycle wb_addr=3, wb_val=0x00001234; stall never asserts.
- Load: mem_addr=0x100, in_addr=5, ready immediate, response 2 cycles after acceptance with rdata=0xDEADBEEF -> bus_req_valid high exactly 1 cycle with addr=0x100, write=0; stall high until the response cycle; then wb_addr=5, wb_val=0xDEADBEEF.
- Store with backpressure: mem_addr=0x200, mem_val=0xCAFEF00D, ready withheld 3 cycles -> request fields stable all 4 cycles; after the response, wb_addr=0.
- Misaligned: mem_addr=0x102 -> no bus_req_valid; misalign pulses 1 cycle; stall=0; wb_addr=0.
- Reset in WAIT, then response pulse -> state IDLE; the response is ignored and wb_addr stays 0.
- Back-to-back: load (dest 7, rdata 0x11) followed by ALU op (dest 2, 0x22) -> wb shows 7/0x11, then next cycle 2/0x22; no duplicate request.
